keypad_scan_4x4: RTL and testbench

- Input-side counterpart of the 4-digit 7-segment sweep driver.
- Sweeps the four columns of a 4x4 matrix keypad (Digilent PmodKYPD layout) one at a time, reads the rows, and debounces across whole scans.
- Emits a hex key code with a one-cycle valid strobe per press.
- Sits between the board Pmod pins and user logic, typically feeding the display digits.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_debounce_fsm.sv | 155 +++++++++++++++
 rtl/keypad_scan_4x4.sv | 97 +++++++++
 tb/tb_keypad_scan_4x4.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // Indexed {row, col}; PmodKYPD legend, rows top to bottom.
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Per-scan press/release debouncer; optional auto-repeat under KEYPAD_AUTOREPEAT_EN.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done,
  input  logic       hit,
  input  logic [3:0] code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be within 1..15");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("REPEAT_SCANS must be >= 1");
  end

  key_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       rep_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rep_q, rep_d;

  // Held at zero outside PRESSED, so every entry into PRESSED starts a fresh period.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != PRESSED) begin
      rep_d = '0;
    end else if (scan_done && hit) begin
      if (rep_q == 16'(REPEAT_SCANS - 1)) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            cand_d = code;
            cnt_d  = 4'd1;
            if (DB_TARGET == 4'd1) begin
              state_d     = PRESSED;
              key_code_d  = code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!hit) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= DB_TARGET) begin
              state_d     = PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            cand_d = code;
            cnt_d  = 4'd1;
          end
        end
        PRESSED: begin
          if (!hit) begin
            cnt_d = 4'd1;
            if (DB_TARGET == 4'd1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            key_valid_d = rep_fire;
          end
        end
        RELEASE: begin
          if (hit) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= DB_TARGET) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 keypad column sweep, row synchronizer and per-scan result capture.
// Auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int NBITS_COMPARE  = 26,
  parameter int COMPARE        = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] state_dbg
);

  if (COMPARE < 4) begin : g_bad_compare
    $error("COMPARE must be >= 4");
  end

  logic [NBITS_COMPARE-1:0] dwell_q, dwell_d;
  logic [1:0]               col_idx_q, col_idx_d;
  logic [NUM_ROWS-1:0]      sync1_q, sync2_q;
  logic                     hit_acc_q, hit_acc_d;
  logic [3:0]               code_acc_q, code_acc_d;
  logic                     tick, scan_done, scan_hit, col_hit, prior_hit;
  logic [3:0]               scan_code, prior_code;
  logic [1:0]               hit_row;

  always_comb begin
    tick      = (dwell_q == NBITS_COMPARE'(COMPARE - 1));
    dwell_d   = tick ? '0 : dwell_q + NBITS_COMPARE'(1);
    col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
    scan_done = tick && (col_idx_q == 2'(NUM_COLS - 1));

    // Walk rows downward so the lowest pressed row is the one left standing.
    col_hit = 1'b0;
    hit_row = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!sync2_q[r]) begin
        col_hit = 1'b1;
        hit_row = 2'(r);
      end
    end

    // Column 0 opens a new scan, so earlier results are discarded there.
    prior_hit  = (col_idx_q == 2'd0) ? 1'b0 : hit_acc_q;
    prior_code = (col_idx_q == 2'd0) ? 4'd0 : code_acc_q;
    scan_hit   = prior_hit | col_hit;
    scan_code  = prior_hit ? prior_code : KEY_MAP[{hit_row, col_idx_q}];

    hit_acc_d  = tick ? scan_hit  : hit_acc_q;
    code_acc_d = tick ? scan_code : code_acc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q    <= '0;
      col_idx_q  <= '0;
      sync1_q    <= '1;
      sync2_q    <= '1;
      hit_acc_q  <= 1'b0;
      code_acc_q <= '0;
    end else begin
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      sync1_q    <= row;
      sync2_q    <= sync1_q;
      hit_acc_q  <= hit_acc_d;
      code_acc_q <= code_acc_d;
    end
  end

  assign col = ~(4'b0001 << col_idx_q);

  // key_valid is a one-clock strobe with no back-pressure: key_code is
  // stable while it is high and stays put until the next accepted press.
  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .scan_done (scan_done),
    .hit       (scan_hit),
    .code      (scan_code),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .state_dbg (state_dbg)
  );

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with a behavioural keypad and a strobe scoreboard.
module tb_keypad_scan_4x4;
  import keypad_pkg::*;

  localparam int CMP = 4;
  localparam int DBS = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP = 4;
  localparam int A_STROBES = 5;
`else
  localparam int REP = 64;
  localparam int A_STROBES = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] state_dbg;
  logic [15:0] keys;

  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  keypad_scan_4x4 #(
    .NBITS_COMPARE  (8),
    .COMPARE        (CMP),
    .DEBOUNCE_SCANS (DBS),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the first clock of the next scan (column 0, count 0).
  task automatic next_scan();
    int guard;
    guard = 0;
    @(negedge clk);
    while (col == 4'b1110 && guard < 100) begin @(negedge clk); guard++; end
    while (col != 4'b1110 && guard < 100) begin @(negedge clk); guard++; end
    check("scan_timeout", 8'(guard >= 100), 8'd0);
  endtask

  task automatic run_scans(input int n);
    for (int i = 0; i < n; i++) next_scan();
  endtask

  task automatic release_and_check_cols();
    rst = 1'b1;
    check("col_after_rst_0", {4'h0, col}, 8'h0E);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("col_after_rst_n", {4'h0, col}, 8'h0E);
    end
    @(negedge clk);
    check("col_second", {4'h0, col}, 8'h0D);
  endtask

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      check("strobe_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) check("strobe_code", {4'h0, key_code}, {4'h0, exp_q.pop_front()});
    end
  end

  initial begin
    keys = '0;
    rst  = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_code", {4'h0, key_code}, 8'h00);
    check("rst_valid", {7'h0, key_valid}, 8'h00);
    check("rst_held", {7'h0, key_held}, 8'h00);
    check("rst_state", {6'h0, state_dbg}, 8'(IDLE));
    release_and_check_cols();

    // 1: reset mid-debounce
    next_scan();
    keys[6] = 1'b1;
    run_scans(2);
    repeat (5) @(negedge clk);
    check("t1_in_debounce", {6'h0, state_dbg}, 8'(DEBOUNCE));
    rst = 1'b0;
    #1;
    check("t1_col", {4'h0, col}, 8'h0E);
    check("t1_code", {4'h0, key_code}, 8'h00);
    check("t1_valid", {7'h0, key_valid}, 8'h00);
    check("t1_held", {7'h0, key_held}, 8'h00);
    check("t1_state", {6'h0, state_dbg}, 8'(IDLE));
    keys = '0;
    repeat (2) @(negedge clk);
    release_and_check_cols();

    // 2: '6' held for 5 scans
    next_scan();
    keys[6] = 1'b1;
    run_scans(2);
    check("t2_no_early", {7'h0, key_valid}, 8'h00);
    exp_q.push_back(4'h6);
    next_scan();
    check("t2_valid", {7'h0, key_valid}, 8'h01);
    check("t2_code", {4'h0, key_code}, 8'h06);
    check("t2_held", {7'h0, key_held}, 8'h01);
    run_scans(2);
    keys = '0;
    run_scans(3);
    check("t2_released", {7'h0, key_held}, 8'h00);
    check("t2_code_kept", {4'h0, key_code}, 8'h06);

    // 3: 2 scans present, 1 absent, 3 present
    keys[6] = 1'b1;
    run_scans(2);
    keys = '0;
    run_scans(1);
    check("t3_no_strobe", {7'h0, key_held}, 8'h00);
    keys[6] = 1'b1;
    run_scans(2);
    check("t3_not_yet", {7'h0, key_valid}, 8'h00);
    exp_q.push_back(4'h6);
    next_scan();
    check("t3_valid", {7'h0, key_valid}, 8'h01);
    keys = '0;
    run_scans(3);

    // 4: '2' and '7' together, column 0 wins
    keys[1] = 1'b1;
    keys[8] = 1'b1;
    exp_q.push_back(4'h7);
    run_scans(3);
    check("t4_valid", {7'h0, key_valid}, 8'h01);
    check("t4_code", {4'h0, key_code}, 8'h07);
    keys = '0;
    run_scans(3);

    // 5: release bounce, then real release, then '9'
    keys[5] = 1'b1;
    exp_q.push_back(4'h5);
    run_scans(3);
    check("t5_code5", {4'h0, key_code}, 8'h05);
    keys = '0;
    run_scans(2);
    check("t5_in_release", {6'h0, state_dbg}, 8'(RELEASE));
    keys[5] = 1'b1;
    run_scans(1);
    check("t5_still_held", {7'h0, key_held}, 8'h01);
    check("t5_no_restrobe", {7'h0, key_valid}, 8'h00);
    keys = '0;
    run_scans(3);
    check("t5_released", {7'h0, key_held}, 8'h00);
    keys[10] = 1'b1;
    exp_q.push_back(4'h9);
    run_scans(3);
    check("t5_valid9", {7'h0, key_valid}, 8'h01);
    check("t5_code9", {4'h0, key_code}, 8'h09);
    keys = '0;
    run_scans(3);

    // 6: 'A' held 20 scans
    keys[3] = 1'b1;
    for (int i = 0; i < A_STROBES; i++) exp_q.push_back(4'hA);
    run_scans(20);
    check("t6_code", {4'h0, key_code}, 8'h0A);
    check("t6_held", {7'h0, key_held}, 8'h01);
    keys = '0;
    run_scans(4);
    check("t6_released", {7'h0, key_held}, 8'h00);
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
